dcache_sram_nway: RTL and testbench

- Parametrised N-way set-associative data-cache storage array with true-LRU replacement and per-line valid/dirty bits.
- Adds a registered 1-cycle lookup response and a flush engine that walks every line and hands dirty lines out on a ready/valid write-back port.
- Sits between the dcache controller FSM and its tag/data storage.
- The controller issues lookups and writes, and uses the reported victim on a miss.

---
 rtl/dcache_sram_nway.sv | 216 +++++++++++++++++++++
 tb/tb_dcache_sram_nway.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_sram_nway.sv
// rtl/dcache_sram_nway.sv - N-way set-associative dcache tag/data store with true-LRU,
// registered 1-cycle lookup response and a flush engine that writes back dirty lines.
module dcache_sram_nway #(
   parameter  int WAYS     = 4,
   parameter  int SET_BITS = 4,
   parameter  int TAG_W    = 23,
   parameter  int LINE_W   = 256,
   localparam int WAY_BITS = $clog2(WAYS)
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                req_i,
   input  logic                write_i,
   input  logic [SET_BITS-1:0] addr_i,
   input  logic [TAG_W-1:0]    tag_i,
   input  logic [LINE_W-1:0]   data_i,
   input  logic                dirty_i,
   output logic                ready_o,
   output logic                rsp_valid_o,
   output logic                hit_o,
   output logic [WAY_BITS-1:0] way_o,
   output logic [TAG_W-1:0]    tag_o,
   output logic [LINE_W-1:0]   data_o,
   output logic                valid_o,
   output logic                dirty_o,
   input  logic                flush_i,
   input  logic                flush_inv_i,
   output logic                busy_o,
   output logic                wb_valid_o,
   input  logic                wb_ready_i,
   output logic [SET_BITS-1:0] wb_set_o,
   output logic [TAG_W-1:0]    wb_tag_o,
   output logic [LINE_W-1:0]   wb_data_o,
   output logic                flush_done_o
);
   localparam int SETS = 2 ** SET_BITS;
   localparam logic [WAY_BITS-1:0] LAST_WAY = WAY_BITS'(WAYS - 1);
   localparam logic [SET_BITS-1:0] LAST_SET = SET_BITS'(SETS - 1);

   typedef enum logic [1:0] {IDLE, SCAN, WB, DONE} state_t;

   logic [TAG_W-1:0]    tag_mem_q  [SETS][WAYS];
   logic [LINE_W-1:0]   data_mem_q [SETS][WAYS];
   logic [WAYS-1:0]     valid_q [SETS], valid_d [SETS];
   logic [WAYS-1:0]     dirty_q [SETS], dirty_d [SETS];
   logic [WAY_BITS-1:0] age_q [SETS][WAYS], age_d [SETS][WAYS];

   state_t              state_q, state_d;
   logic                inv_q, inv_d;
   logic [SET_BITS-1:0] cur_set_q, cur_set_d;
   logic [WAY_BITS-1:0] cur_way_q, cur_way_d;

   logic                rsp_valid_q, rsp_valid_d;
   logic                hit_q, hit_d;
   logic [WAY_BITS-1:0] way_q, way_d;
   logic [TAG_W-1:0]    rsp_tag_q, rsp_tag_d;
   logic [LINE_W-1:0]   rsp_data_q, rsp_data_d;
   logic                rsp_lvalid_q, rsp_lvalid_d;
   logic                rsp_dirty_q, rsp_dirty_d;

   logic                accept, mem_we, advance, hit;
   logic [WAY_BITS-1:0] hit_way, victim, sel_way;

   // Victim: lowest invalid way wins over the oldest way.
   always_comb begin
      hit     = 1'b0;
      hit_way = '0;
      victim  = '0;
      for (int w = 0; w < WAYS; w++) begin
         if (valid_q[addr_i][w] && tag_mem_q[addr_i][w] == tag_i) begin
            hit     = 1'b1;
            hit_way = WAY_BITS'(w);
         end
         if (age_q[addr_i][w] == LAST_WAY) victim = WAY_BITS'(w);
      end
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (!valid_q[addr_i][w]) victim = WAY_BITS'(w);
      end
      sel_way = hit ? hit_way : victim;
   end

   always_comb begin
      accept       = req_i && (state_q == IDLE);
      mem_we       = accept && write_i;
      advance      = 1'b0;
      valid_d      = valid_q;
      dirty_d      = dirty_q;
      age_d        = age_q;
      state_d      = state_q;
      inv_d        = inv_q;
      cur_set_d    = cur_set_q;
      cur_way_d    = cur_way_q;
      rsp_valid_d  = accept;
      hit_d        = hit_q;
      way_d        = way_q;
      rsp_tag_d    = rsp_tag_q;
      rsp_data_d   = rsp_data_q;
      rsp_lvalid_d = rsp_lvalid_q;
      rsp_dirty_d  = rsp_dirty_q;

      if (accept) begin
         hit_d        = hit;
         way_d        = sel_way;
         rsp_tag_d    = tag_mem_q[addr_i][sel_way];
         rsp_data_d   = data_mem_q[addr_i][sel_way];
         rsp_lvalid_d = valid_q[addr_i][sel_way];
         rsp_dirty_d  = dirty_q[addr_i][sel_way];
         if (write_i) begin
            valid_d[addr_i][sel_way] = 1'b1;
            dirty_d[addr_i][sel_way] = dirty_i;
         end
         if (write_i || hit) begin
            for (int w = 0; w < WAYS; w++) begin
               if (age_q[addr_i][w] < age_q[addr_i][sel_way])
                  age_d[addr_i][w] = age_q[addr_i][w] + WAY_BITS'(1);
            end
            age_d[addr_i][sel_way] = '0;
         end
      end

      case (state_q)
         IDLE: begin
            if (flush_i) begin
               inv_d     = flush_inv_i;
               cur_set_d = '0;
               cur_way_d = '0;
               state_d   = SCAN;
            end
         end
         SCAN: begin
            if (valid_q[cur_set_q][cur_way_q] && dirty_q[cur_set_q][cur_way_q]) begin
               state_d = WB;
            end else begin
               if (inv_q) valid_d[cur_set_q][cur_way_q] = 1'b0;
               advance = 1'b1;
            end
         end
         WB: begin
            if (wb_ready_i) begin
               dirty_d[cur_set_q][cur_way_q] = 1'b0;
               if (inv_q) valid_d[cur_set_q][cur_way_q] = 1'b0;
               advance = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      if (advance) begin
         if (cur_set_q == LAST_SET && cur_way_q == LAST_WAY) begin
            state_d = DONE;
         end else begin
            state_d   = SCAN;
            cur_way_d = cur_way_q + WAY_BITS'(1);
            if (cur_way_q == LAST_WAY) cur_set_d = cur_set_q + SET_BITS'(1);
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int s = 0; s < SETS; s++) begin
            valid_q[s] <= '0;
            dirty_q[s] <= '0;
            for (int w = 0; w < WAYS; w++) age_q[s][w] <= WAY_BITS'(w);
         end
         state_q      <= IDLE;
         inv_q        <= 1'b0;
         cur_set_q    <= '0;
         cur_way_q    <= '0;
         rsp_valid_q  <= 1'b0;
         hit_q        <= 1'b0;
         way_q        <= '0;
         rsp_tag_q    <= '0;
         rsp_data_q   <= '0;
         rsp_lvalid_q <= 1'b0;
         rsp_dirty_q  <= 1'b0;
      end else begin
         valid_q      <= valid_d;
         dirty_q      <= dirty_d;
         age_q        <= age_d;
         state_q      <= state_d;
         inv_q        <= inv_d;
         cur_set_q    <= cur_set_d;
         cur_way_q    <= cur_way_d;
         rsp_valid_q  <= rsp_valid_d;
         hit_q        <= hit_d;
         way_q        <= way_d;
         rsp_tag_q    <= rsp_tag_d;
         rsp_data_q   <= rsp_data_d;
         rsp_lvalid_q <= rsp_lvalid_d;
         rsp_dirty_q  <= rsp_dirty_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (mem_we) begin
         tag_mem_q[addr_i][sel_way]  <= tag_i;
         data_mem_q[addr_i][sel_way] <= data_i;
      end
   end

   assign busy_o       = (state_q != IDLE);
   assign ready_o      = !busy_o;
   assign wb_valid_o   = (state_q == WB);
   assign flush_done_o = (state_q == DONE);
   assign wb_set_o     = wb_valid_o ? cur_set_q : '0;
   assign wb_tag_o     = wb_valid_o ? tag_mem_q[cur_set_q][cur_way_q] : '0;
   assign wb_data_o    = wb_valid_o ? data_mem_q[cur_set_q][cur_way_q] : '0;
   assign rsp_valid_o  = rsp_valid_q;
   assign hit_o        = hit_q;
   assign way_o        = way_q;
   assign tag_o        = rsp_tag_q;
   assign data_o       = rsp_data_q;
   assign valid_o      = rsp_lvalid_q;
   assign dirty_o      = rsp_dirty_q;
endmodule

// File: tb/tb_dcache_sram_nway.sv
// tb/tb_dcache_sram_nway.sv - randomized scoreboard bench for dcache_sram_nway against
// a recency-list reference model.
module tb_dcache_sram_nway;
   localparam int WAYS     = 4;
   localparam int SET_BITS = 4;
   localparam int TAG_W    = 23;
   localparam int LINE_W   = 256;
   localparam int WAY_BITS = $clog2(WAYS);
   localparam int SETS     = 2 ** SET_BITS;

   logic                clk_i = 1'b0, rst_i = 1'b1;
   logic                req_i = 1'b0, write_i = 1'b0, dirty_i = 1'b0;
   logic [SET_BITS-1:0] addr_i = '0;
   logic [TAG_W-1:0]    tag_i = '0;
   logic [LINE_W-1:0]   data_i = '0;
   logic                flush_i = 1'b0, flush_inv_i = 1'b0, wb_ready_i = 1'b0;
   logic                ready_o, rsp_valid_o, hit_o, valid_o, dirty_o;
   logic [WAY_BITS-1:0] way_o;
   logic [TAG_W-1:0]    tag_o, wb_tag_o;
   logic [LINE_W-1:0]   data_o, wb_data_o;
   logic                busy_o, wb_valid_o, flush_done_o;
   logic [SET_BITS-1:0] wb_set_o;

   dcache_sram_nway #(.WAYS(WAYS), .SET_BITS(SET_BITS), .TAG_W(TAG_W), .LINE_W(LINE_W)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .write_i(write_i), .addr_i(addr_i),
      .tag_i(tag_i), .data_i(data_i), .dirty_i(dirty_i), .ready_o(ready_o),
      .rsp_valid_o(rsp_valid_o), .hit_o(hit_o), .way_o(way_o), .tag_o(tag_o), .data_o(data_o),
      .valid_o(valid_o), .dirty_o(dirty_o), .flush_i(flush_i), .flush_inv_i(flush_inv_i),
      .busy_o(busy_o), .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i), .wb_set_o(wb_set_o),
      .wb_tag_o(wb_tag_o), .wb_data_o(wb_data_o), .flush_done_o(flush_done_o));

   always #5 clk_i = ~clk_i;

   typedef struct {
      bit hit; logic [WAY_BITS-1:0] way; logic [TAG_W-1:0] tag; logic [LINE_W-1:0] data;
      bit valid; bit dirty; bit known;
   } rsp_t;
   typedef struct { logic [SET_BITS-1:0] set; logic [TAG_W-1:0] tag; logic [LINE_W-1:0] data; } wb_t;

   rsp_t exp_q[$];
   wb_t  wb_q[$];
   int   checks = 0, errors = 0, done_cnt = 0, flush_cnt = 0;
   bit   bp_mode = 1'b0;

   // Reference state; order[s][0] is the most recently used way of set s.
   bit              m_valid [SETS][WAYS], m_dirty [SETS][WAYS], m_known [SETS][WAYS];
   logic [TAG_W-1:0]  m_tag  [SETS][WAYS];
   logic [LINE_W-1:0] m_data [SETS][WAYS];
   int              order [SETS][WAYS];

   function automatic logic [LINE_W-1:0] rnd_line();
      logic [LINE_W-1:0] v;
      for (int i = 0; i < LINE_W / 32; i++) v[i*32 +: 32] = $urandom;
      return v;
   endfunction

   task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s: actual %0h required %0h", name, act, req);
      end
   endtask

   task automatic model_reset();
      for (int s = 0; s < SETS; s++)
         for (int w = 0; w < WAYS; w++) begin
            m_valid[s][w] = 0; m_dirty[s][w] = 0; m_known[s][w] = 0; order[s][w] = w;
         end
      wb_q.delete();
   endtask

   task automatic touch(input int s, input int k);
      int p = 0;
      for (int i = 0; i < WAYS; i++) if (order[s][i] == k) p = i;
      for (int i = p; i > 0; i--) order[s][i] = order[s][i-1];
      order[s][0] = k;
   endtask

   task automatic prep(input bit wr, input int s, input logic [TAG_W-1:0] t,
                       input logic [LINE_W-1:0] d, input bit dy);
      rsp_t r; int hw = -1; int w = -1;
      for (int i = 0; i < WAYS; i++) if (m_valid[s][i] && m_tag[s][i] == t) hw = i;
      if (hw >= 0) w = hw;
      else begin
         for (int i = WAYS - 1; i >= 0; i--) if (!m_valid[s][i]) w = i;
         if (w < 0) w = order[s][WAYS-1];
      end
      r.hit = (hw >= 0); r.way = WAY_BITS'(w); r.tag = m_tag[s][w]; r.data = m_data[s][w];
      r.valid = m_valid[s][w]; r.dirty = m_dirty[s][w]; r.known = m_known[s][w];
      exp_q.push_back(r);
      if (wr) begin
         m_tag[s][w] = t; m_data[s][w] = d; m_valid[s][w] = 1; m_dirty[s][w] = dy; m_known[s][w] = 1;
      end
      if (wr || hw >= 0) touch(s, w);
      req_i = 1'b1; write_i = wr; addr_i = SET_BITS'(s); tag_i = t; data_i = d; dirty_i = dy;
   endtask

   task automatic issue(input bit wr, input int s, input logic [TAG_W-1:0] t,
                        input logic [LINE_W-1:0] d, input bit dy);
      prep(wr, s, t, d, dy);
      @(posedge clk_i); #1;
      req_i = 1'b0;
   endtask

   task automatic model_flush(input bit inv);
      wb_t e;
      for (int s = 0; s < SETS; s++)
         for (int w = 0; w < WAYS; w++) begin
            if (m_valid[s][w] && m_dirty[s][w]) begin
               e.set = SET_BITS'(s); e.tag = m_tag[s][w]; e.data = m_data[s][w];
               wb_q.push_back(e);
               m_dirty[s][w] = 0;
            end
            if (inv) m_valid[s][w] = 0;
         end
   endtask

   task automatic do_flush(input bit inv, input bit bp, input bit co);
      int cyc = 0, stall = 0, d0 = done_cnt;
      if (co) prep($urandom_range(0, 1), $urandom_range(0, 3), TAG_W'($urandom_range(0, 5)),
                   rnd_line(), $urandom_range(0, 1));
      flush_i = 1'b1; flush_inv_i = inv;
      @(posedge clk_i); #1;
      flush_i = 1'b0; req_i = 1'b0;
      model_flush(inv);
      flush_cnt++;
      bp_mode = bp;
      while (!flush_done_o && cyc < 3000) begin
         if (bp) begin
            if (wb_valid_o && stall < 3) begin wb_ready_i = 1'b0; stall++; end
            else if (wb_valid_o) begin wb_ready_i = 1'b1; stall = 0; end
            else wb_ready_i = 1'b0;
         end else wb_ready_i = ($urandom_range(0, 2) != 0);
         req_i = $urandom_range(0, 1); write_i = $urandom_range(0, 1);
         addr_i = SET_BITS'($urandom_range(0, 3)); tag_i = TAG_W'($urandom_range(0, 5));
         data_i = rnd_line(); dirty_i = $urandom_range(0, 1);
         @(posedge clk_i); #1;
         cyc++;
      end
      req_i = 1'b0; wb_ready_i = 1'b0;
      chk(flush_done_o, "flush_done_seen", 64'(flush_done_o), 64'd1);
      @(posedge clk_i); #1;
      chk(done_cnt == d0 + 1, "flush_done_pulse_count", 64'(done_cnt - d0), 64'd1);
      chk(ready_o == 1'b1, "ready_after_flush", 64'(ready_o), 64'd1);
      chk(wb_q.size() == 0, "wb_all_seen", 64'(wb_q.size()), 64'd0);
      bp_mode = 1'b0;
   endtask

   task automatic do_reset();
      @(posedge clk_i); #1;
      rst_i = 1'b1;
      @(posedge clk_i); #1;
      rst_i = 1'b0;
      model_reset();
   endtask

   // Monitor: response scoreboard and write-back checks.
   rsp_t e;
   wb_t  we;
   int   hold = 0;
   bit   prev_stall = 0;
   logic [SET_BITS-1:0] p_set;
   logic [TAG_W-1:0]    p_tag;
   logic [LINE_W-1:0]   p_data;
   always @(negedge clk_i) begin
      if (rst_i) begin
         hold = 0; prev_stall = 0;
      end else begin
         if (flush_done_o) done_cnt++;
         if (rsp_valid_o) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL rsp_unexpected: actual rsp_valid_o=1 required no response");
            end else begin
               e = exp_q.pop_front();
               if (hit_o !== e.hit || way_o !== e.way || valid_o !== e.valid || dirty_o !== e.dirty ||
                   (e.known && (tag_o !== e.tag || data_o !== e.data))) begin
                  errors++;
                  $display("FAIL rsp: actual hit=%0d way=%0d valid=%0d dirty=%0d tag=%0h data=%0h required hit=%0d way=%0d valid=%0d dirty=%0d tag=%0h data=%0h",
                           hit_o, way_o, valid_o, dirty_o, tag_o, data_o,
                           e.hit, e.way, e.valid, e.dirty, e.tag, e.data);
               end
            end
         end
         if (prev_stall) begin
            checks++;
            if (!wb_valid_o || wb_set_o !== p_set || wb_tag_o !== p_tag || wb_data_o !== p_data) begin
               errors++;
               $display("FAIL wb_stable: actual valid=%0d set=%0h tag=%0h required valid=1 set=%0h tag=%0h",
                        wb_valid_o, wb_set_o, wb_tag_o, p_set, p_tag);
            end
         end
         if (wb_valid_o) hold++;
         if (wb_valid_o && wb_ready_i) begin
            checks++;
            if (wb_q.size() == 0) begin
               errors++;
               $display("FAIL wb_unexpected: actual set=%0h tag=%0h required no write-back", wb_set_o, wb_tag_o);
            end else begin
               we = wb_q.pop_front();
               if (wb_set_o !== we.set || wb_tag_o !== we.tag || wb_data_o !== we.data) begin
                  errors++;
                  $display("FAIL wb_line: actual set=%0h tag=%0h data=%0h required set=%0h tag=%0h data=%0h",
                           wb_set_o, wb_tag_o, wb_data_o, we.set, we.tag, we.data);
               end
            end
            if (bp_mode) begin
               checks++;
               if (hold != 4) begin
                  errors++;
                  $display("FAIL wb_hold_cycles: actual %0d required 4", hold);
               end
            end
            hold = 0;
         end
         prev_stall = wb_valid_o && !wb_ready_i;
         p_set = wb_set_o; p_tag = wb_tag_o; p_data = wb_data_o;
      end
   end

   initial begin
      int cyc, d0;
      model_reset();
      repeat (2) @(posedge clk_i);
      #1;
      chk(busy_o == 0 && wb_valid_o == 0 && flush_done_o == 0 && rsp_valid_o == 0,
          "reset_outputs_in_reset", {busy_o, wb_valid_o, flush_done_o, rsp_valid_o}, 64'd0);
      rst_i = 1'b0;
      @(posedge clk_i); #1;
      chk(ready_o == 1 && rsp_valid_o == 0 && hit_o == 0 && valid_o == 0, "reset_outputs",
          {ready_o, rsp_valid_o, hit_o, valid_o}, 64'h8);

      // Cold miss, then fill set 3 and exercise LRU replacement.
      issue(0, 3, 'h12, rnd_line(), 0);
      for (int i = 0; i < 4; i++) issue(1, 3, TAG_W'('h10 + i), rnd_line(), 0);
      issue(0, 3, 'h10, '0, 0);
      issue(1, 3, 'h20, rnd_line(), 1);
      issue(0, 3, 'h20, '0, 0);

      // Write-hit updates data and dirty.
      issue(1, 5, 'h11, rnd_line(), 0);
      issue(1, 5, 'h11, rnd_line(), 1);
      issue(0, 5, 'h11, '0, 0);

      // Flush with backpressure on two dirty lines.
      do_reset();
      issue(1, 0, 'h1, rnd_line(), 0);
      issue(1, 0, 'h2, rnd_line(), 0);
      issue(1, 0, 'h3, rnd_line(), 1);
      issue(1, 7, 'h4, rnd_line(), 0);
      issue(1, 7, 'h5, rnd_line(), 1);
      do_flush(0, 1, 0);
      issue(0, 0, 'h3, '0, 0);
      issue(0, 7, 'h5, '0, 0);

      // Flush-invalidate with a coincident request and requests during busy.
      for (int i = 0; i < 20; i++)
         issue(1, $urandom_range(0, 15), TAG_W'($urandom_range(0, 7)), rnd_line(), $urandom_range(0, 1));
      do_flush(1, 0, 1);
      for (int s = 0; s < SETS; s++) issue(0, s, TAG_W'($urandom_range(0, 7)), '0, 0);

      // Reset while a write-back is pending.
      issue(1, 2, 'h33, rnd_line(), 1);
      flush_i = 1'b1; flush_inv_i = 1'b0;
      @(posedge clk_i); #1;
      flush_i = 1'b0;
      cyc = 0;
      while (!wb_valid_o && cyc < 500) begin @(posedge clk_i); #1; cyc++; end
      chk(wb_valid_o, "wb_reached_before_reset", 64'(wb_valid_o), 64'd1);
      d0 = done_cnt;
      rst_i = 1'b1;
      #1;
      chk(wb_valid_o == 0 && busy_o == 0, "async_reset_drops_wb", {wb_valid_o, busy_o}, 64'd0);
      @(posedge clk_i); #1;
      rst_i = 1'b0;
      model_reset();
      repeat (3) @(posedge clk_i);
      #1;
      chk(done_cnt == d0, "no_done_after_reset", 64'(done_cnt), 64'(d0));
      issue(0, 2, 'h33, '0, 0);
      issue(0, 3, 'h20, '0, 0);

      // Randomized traffic with occasional flushes.
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 29) == 0) do_flush($urandom_range(0, 1), 0, $urandom_range(0, 1));
         else issue($urandom_range(0, 1), $urandom_range(0, 3), TAG_W'($urandom_range(0, 5)),
                    rnd_line(), $urandom_range(0, 1));
      end

      @(posedge clk_i); #1;
      @(posedge clk_i); #1;
      chk(exp_q.size() == 0, "all_responses_seen", 64'(exp_q.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
